// File: rtl/rasm_pkg.sv
// Shared types and constants for the trigger/capture controller.
// Trigger source bit positions follow the enable vector layout {SPI, UART, ch[NUM_CH-1:0]}.
package rasm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } cap_state_t;

  localparam int ADDR_W_DEF = 9;
  localparam int NUM_CH_DEF = 5;
  localparam int DEPTH      = 2 ** ADDR_W_DEF;
  localparam int TRIG_UART  = NUM_CH_DEF;
  localparam int TRIG_SPI   = NUM_CH_DEF + 1;

endpackage

// File: rtl/trig_src_combine.sv
// Masks trigger sources with their enables and ORs them into one hit.
// Holds a pending flag so a pulse landing between sample strobes is not lost.
module trig_src_combine
  import rasm_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_uart_trig,
  input  logic              i_spi_trig,
  input  logic [NUM_CH-1:0] i_ch_trig,
  input  logic [NUM_CH+1:0] i_src_en,
  input  logic              i_arm,
  input  logic              i_clr,
  output logic              o_hit,
  output logic              o_pend
);

  logic [NUM_CH+1:0] w_src;
  logic              r_pend;

  assign w_src = {i_spi_trig, i_uart_trig, i_ch_trig};
  assign o_hit = |(w_src & i_src_en);

  // Pending only accumulates while armed; any other state drops it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 1'b0;
    end else if (i_clr || !i_arm) begin
      r_pend <= 1'b0;
    end else if (o_hit) begin
      r_pend <= 1'b1;
    end
  end

  assign o_pend = r_pend;

endmodule

// File: rtl/trig_capture_ctrl.sv
// Circular sample-RAM capture sequencer: pre-trigger fill, trigger arbitration, post-trigger count.
//   state    | meaning
//   ST_IDLE  | waiting for run
//   ST_FILL  | writing pre-trigger samples until fill count reaches pre
//   ST_ARMED | pre-trigger window full, wrapping writes, waiting for trigger
//   ST_POST  | trigger taken, writing tp_eff post-trigger samples
//   ST_DONE  | capture complete, writes stopped, flag sticky
module trig_capture_ctrl
  import rasm_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_CH = NUM_CH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_run,
  input  logic              i_stop,
  input  logic              i_smpl_en,
  input  logic              i_uart_trig,
  input  logic              i_spi_trig,
  input  logic [NUM_CH-1:0] i_ch_trig,
  input  logic [NUM_CH+1:0] i_trig_src_en,
  input  logic [ADDR_W-1:0] i_trig_pos,
  input  logic              i_clr_done,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic              o_armed,
  output logic              o_triggered,
  output logic              o_capture_done,
  output logic [ADDR_W-1:0] o_trig_addr
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  cap_state_t        r_state;
  cap_state_t        w_next;
  cap_state_t        w_start_state;
  logic [ADDR_W-1:0] r_waddr;
  logic [ADDR_W-1:0] r_smpl_cnt;
  logic [ADDR_W-1:0] r_post_cnt;
  logic [ADDR_W-1:0] r_tp_eff;
  logic [ADDR_W-1:0] r_trig_addr;
  logic              r_triggered;
  logic              r_armed;

  logic [ADDR_W-1:0] w_pre;
  logic [ADDR_W-1:0] w_pre_run;
  logic [ADDR_W-1:0] w_smpl_inc;
  logic [ADDR_W-1:0] w_post_inc;
  logic [ADDR_W-1:0] w_waddr_inc;
  logic              w_capturing;
  logic              w_run_ok;
  logic              w_hit;
  logic              w_pend;
  logic              w_accept;
  logic              w_we;

  // trig_pos is already ADDR_W bits, so min(trig_pos, DEPTH-1) is trig_pos itself.
  assign w_pre_run   = ADDR_MAX - i_trig_pos;
  assign w_pre       = ADDR_MAX - r_tp_eff;
  assign w_smpl_inc  = r_smpl_cnt + 1'b1;
  assign w_post_inc  = r_post_cnt + 1'b1;
  assign w_waddr_inc = r_waddr + 1'b1;

  assign w_capturing = (r_state == ST_FILL) || (r_state == ST_ARMED) || (r_state == ST_POST);
  assign w_run_ok    = i_run && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_accept    = (r_state == ST_ARMED) && i_smpl_en && (w_pend || w_hit);
  assign w_we        = w_capturing && i_smpl_en;
  assign w_start_state = (w_pre_run == '0) ? ST_ARMED : ST_FILL;

  trig_src_combine #(
    .NUM_CH (NUM_CH)
  ) u_trig_src_combine (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_uart_trig (i_uart_trig),
    .i_spi_trig  (i_spi_trig),
    .i_ch_trig   (i_ch_trig),
    .i_src_en    (i_trig_src_en),
    .i_arm       (r_state == ST_ARMED),
    .i_clr       (w_accept || i_stop),
    .o_hit       (w_hit),
    .o_pend      (w_pend)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (i_run) w_next = w_start_state;
      end
      ST_FILL: begin
        if (i_smpl_en && (w_smpl_inc == w_pre)) w_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (w_accept) w_next = (r_tp_eff == '0) ? ST_DONE : ST_POST;
      end
      ST_POST: begin
        if (i_smpl_en && (w_post_inc == r_tp_eff)) w_next = ST_DONE;
      end
      ST_DONE: begin
        if (i_run) begin
          w_next = w_start_state;
        end else if (i_clr_done) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    if (i_stop) w_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waddr     <= '0;
      r_smpl_cnt  <= '0;
      r_post_cnt  <= '0;
      r_tp_eff    <= '0;
      r_trig_addr <= '0;
      r_triggered <= 1'b0;
      r_armed     <= 1'b0;
    end else if (i_stop) begin
      r_triggered <= 1'b0;
      r_armed     <= 1'b0;
    end else if (w_run_ok) begin
      r_waddr     <= '0;
      r_smpl_cnt  <= '0;
      r_post_cnt  <= '0;
      r_tp_eff    <= i_trig_pos;
      r_triggered <= 1'b0;
      r_armed     <= (w_pre_run == '0);
    end else begin
      if (w_we) r_waddr <= w_waddr_inc;
      if ((r_state == ST_FILL) && i_smpl_en) r_smpl_cnt <= w_smpl_inc;
      if ((r_state == ST_FILL) && (w_next == ST_ARMED)) r_armed <= 1'b1;
      if (w_accept) begin
        r_trig_addr <= w_waddr_inc;
        r_triggered <= 1'b1;
        r_post_cnt  <= '0;
      end
      if ((r_state == ST_POST) && i_smpl_en) r_post_cnt <= w_post_inc;
    end
  end

  assign o_we           = w_we;
  assign o_waddr        = r_waddr;
  assign o_armed        = r_armed;
  assign o_triggered    = r_triggered;
  assign o_capture_done = (r_state == ST_DONE);
  assign o_trig_addr    = r_trig_addr;

endmodule

// File: tb/tb_trig_capture_ctrl.sv
// Bench for trig_capture_ctrl: random strobes/triggers against a sample-count reference model.
// The model tracks samples written and the index of the trigger sample; all outputs derive from those.
module tb_trig_capture_ctrl;
  import rasm_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       run, stop, smpl, uart, spi, clr;
  logic [4:0] ch;
  logic [6:0] en;
  logic [8:0] tp;
  logic       o_we, o_armed, o_triggered, o_capture_done;
  logic [8:0] o_waddr, o_trig_addr;

  int checks = 0;
  int errors = 0;

  // reference model
  bit m_active = 0;
  bit m_zero   = 1;
  bit m_pend   = 0;
  int m_n      = 0;
  int m_k      = -1;
  int m_tp     = 0;
  int m_pre    = 0;

  trig_capture_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_run          (run),
    .i_stop         (stop),
    .i_smpl_en      (smpl),
    .i_uart_trig    (uart),
    .i_spi_trig     (spi),
    .i_ch_trig      (ch),
    .i_trig_src_en  (en),
    .i_trig_pos     (tp),
    .i_clr_done     (clr),
    .o_we           (o_we),
    .o_waddr        (o_waddr),
    .o_armed        (o_armed),
    .o_triggered    (o_triggered),
    .o_capture_done (o_capture_done),
    .o_trig_addr    (o_trig_addr)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_done();
    return m_active && (m_k >= 0) && (m_n == m_k + 1 + m_tp);
  endfunction

  // One clock: inputs already driven by caller; check we, advance model, check registers.
  task automatic step();
    bit hit, arm_ok, d;
    @(negedge clk);
    chk("we", o_we, m_active && !m_done() && smpl);
    hit = |({spi, uart, ch} & en);
    d = m_done();
    if (stop) begin
      m_active = 0; m_zero = 1;
    end else if (run && (!m_active || d)) begin
      m_active = 1; m_zero = 0; m_n = 0; m_k = -1; m_pend = 0;
      m_tp = int'(tp); m_pre = DEPTH - 1 - int'(tp);
    end else if (clr && d) begin
      m_active = 0; m_zero = 0;
    end else if (m_active && !d) begin
      arm_ok = (m_n >= m_pre) && (m_k < 0);
      if (smpl) begin
        if (arm_ok && (m_pend || hit)) m_k = m_n;
        m_n++;
      end else if (arm_ok && hit) begin
        m_pend = 1;
      end
    end
    @(posedge clk);
    #1;
    run = 0; stop = 0; clr = 0; uart = 0; spi = 0; ch = '0; smpl = 0;
    chk("capture_done", o_capture_done, m_done());
    if (m_active) begin
      chk("waddr", o_waddr, m_n % DEPTH);
      chk("armed", o_armed, m_n >= m_pre);
      chk("triggered", o_triggered, m_k >= 0);
      if (m_k >= 0) chk("trig_addr", o_trig_addr, (m_k + 1) % DEPTH);
    end
    if (m_zero) begin
      chk("armed_zero", o_armed, 0);
      chk("triggered_zero", o_triggered, 0);
    end
  endtask

  initial begin
    int cyc;
    bit sent, fsent;
    rst_n = 0; run = 0; stop = 0; smpl = 0; uart = 0; spi = 0; clr = 0;
    ch = '0; en = '0; tp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", o_we, 0);
    chk("rst_waddr", o_waddr, 0);
    chk("rst_armed", o_armed, 0);
    chk("rst_triggered", o_triggered, 0);
    chk("rst_done", o_capture_done, 0);
    chk("rst_trig_addr", o_trig_addr, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // A: tp=256, UART only; UART in FILL ignored, UART between strobes latched at sample 400
    en = '0; en[TRIG_UART] = 1'b1; tp = 9'd256; run = 1; step();
    cyc = 0; sent = 0; fsent = 0;
    while (!m_done() && cyc < 5000) begin
      smpl = ($urandom_range(0, 3) != 0);
      ch   = 5'($urandom);
      spi  = 1'($urandom_range(0, 1));
      if (!fsent && m_n == 100) begin uart = 1; fsent = 1; end
      if (!sent && m_n == 400) begin uart = 1; smpl = 0; sent = 1; end
      step(); cyc++;
    end
    chk("a_done", o_capture_done, 1);
    chk("a_trig_addr", o_trig_addr, 401);
    chk("a_waddr", o_waddr, (401 + 256) % 512);

    // B: run from DONE, tp=0, SPI only; SPI in FILL and UART ignored
    en = '0; en[TRIG_SPI] = 1'b1; tp = 9'd0; run = 1; step();
    chk("b_restart_waddr", o_waddr, 0);
    cyc = 0; sent = 0; fsent = 0;
    while (!m_done() && cyc < 5000) begin
      smpl = ($urandom_range(0, 3) != 0);
      ch   = 5'($urandom);
      uart = 1'($urandom_range(0, 1));
      if (!fsent && m_n == 50) begin spi = 1; fsent = 1; end
      if (!sent && m_n == 600) begin spi = 1; smpl = 1; sent = 1; end
      step(); cyc++;
    end
    chk("b_done", o_capture_done, 1);
    chk("b_trig_addr", o_trig_addr, 89);
    chk("b_waddr", o_waddr, 89);

    // clr_done returns to IDLE; a strobe there writes nothing
    clr = 1; step();
    chk("clr_done_flag", o_capture_done, 0);
    smpl = 1; step();

    // C: tp=511, ch[2] only; armed at once, trigger after 3 wraps
    en = '0; en[2] = 1'b1; tp = 9'd511; run = 1; step();
    chk("c_armed_now", o_armed, 1);
    cyc = 0; sent = 0;
    while (!m_done() && cyc < 8000) begin
      smpl = ($urandom_range(0, 3) != 0);
      ch   = 5'($urandom) & 5'b11011;
      uart = 1'($urandom_range(0, 1));
      spi  = 1'($urandom_range(0, 1));
      if (!sent && m_n == 1600) begin ch[2] = 1; smpl = 1; sent = 1; end
      step(); cyc++;
    end
    chk("c_done", o_capture_done, 1);
    chk("c_trig_addr", o_trig_addr, 1601 % 512);
    chk("c_waddr", o_waddr, (1601 + 511) % 512);

    // D: all sources, random triggers; stop mid-POST
    en = '1; tp = 9'($urandom_range(4, 300)); run = 1; step();
    cyc = 0;
    while (!(m_k >= 0 && m_n >= m_k + 3) && cyc < 5000) begin
      smpl = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) ch = 5'($urandom_range(1, 31));
      step(); cyc++;
    end
    chk("d_in_post", o_triggered, 1);
    stop = 1; run = 1; step();
    chk("d_stop_armed", o_armed, 0);
    chk("d_stop_trig", o_triggered, 0);
    chk("d_stop_done", o_capture_done, 0);

    en = '1; tp = 9'($urandom_range(0, 20)); run = 1; step();
    cyc = 0;
    while (!m_done() && cyc < 5000) begin
      smpl = 1'($urandom_range(0, 1));
      uart = ($urandom_range(0, 3) == 0);
      step(); cyc++;
    end
    chk("d2_done", o_capture_done, 1);
    stop = 1; run = 1; clr = 1; step();
    chk("d2_stop_armed", o_armed, 0);
    chk("d2_stop_trig", o_triggered, 0);
    chk("d2_stop_done", o_capture_done, 0);
    smpl = 1; step();
    tp = 9'd100; run = 1; step();
    chk("d3_waddr0", o_waddr, 0);
    smpl = 1; step();
    smpl = 1; step();
    chk("d3_waddr2", o_waddr, 2);
    chk("d3_not_armed", o_armed, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
